// File: rtl/gray_codec_pipe_pkg.sv
// Shared definitions for the pipelined Gray<->binary codec: mode encodings and
// the chunk-size helper used to split the XOR prefix chain across stages.
package gray_codec_pipe_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/gray_codec_pipe_if.sv
// Valid/ready stream bundle for the codec: input beat side and result side.
interface gray_codec_pipe_if #(
  parameter int BIT_WIDTH = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic [BIT_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_mode;
  logic [BIT_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data
  );

endinterface

// File: rtl/gray_codec_pipe_stage.sv
// One codec pipeline stage: resolves its MSB-first chunk of the Gray->binary
// prefix chain (or the whole binary->Gray word in stage 0) and holds the beat.
module gray_codec_stage
  import gray_codec_pipe_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int CHUNK     = 4,
  parameter int STAGE_IDX = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 prev_valid,
  input  logic                 prev_mode,
  input  logic [BIT_WIDTH-1:0] prev_data,
  input  logic                 prev_carry,
  input  logic                 next_ready,
  output logic                 valid,
  output logic                 mode,
  output logic [BIT_WIDTH-1:0] data,
  output logic                 carry,
  output logic                 ready
);

  // Chunk bounds; HI goes negative for trailing stages that have nothing left to resolve.
  localparam int HI     = BIT_WIDTH - 1 - STAGE_IDX * CHUNK;
  localparam int LO_RAW = BIT_WIDTH - (STAGE_IDX + 1) * CHUNK;
  localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

  logic                 valid_r;
  logic                 mode_r;
  logic                 carry_r;
  logic [BIT_WIDTH-1:0] data_r;
  logic [BIT_WIDTH-1:0] data_nxt_s;
  logic                 carry_nxt_s;
  logic                 load_s;

  assign ready  = !valid_r || next_ready;
  assign load_s = prev_valid && ready;

  // Chunk conversion: bits above the chunk are already binary, bits below stay Gray.
  always_comb begin
    data_nxt_s  = prev_data;
    carry_nxt_s = prev_carry;
    if (prev_mode == MODE_B2G) begin
      if (STAGE_IDX == 0) begin
        data_nxt_s = prev_data ^ (prev_data >> 1);
      end else begin
        data_nxt_s = prev_data;
      end
    end else begin
      for (int i = BIT_WIDTH - 1; i >= 0; i--) begin
        if ((i <= HI) && (i >= LO)) begin
          carry_nxt_s   = carry_nxt_s ^ prev_data[i];
          data_nxt_s[i] = carry_nxt_s;
        end else begin
          data_nxt_s[i] = prev_data[i];
        end
      end
    end
  end

  // Stage register: load on accept, empty when the beat leaves with nothing behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      mode_r  <= 1'b0;
      carry_r <= 1'b0;
      data_r  <= '0;
    end else if (load_s) begin
      valid_r <= 1'b1;
      mode_r  <= prev_mode;
      carry_r <= carry_nxt_s;
      data_r  <= data_nxt_s;
    end else if (next_ready) begin
      valid_r <= 1'b0;
    end
  end

  assign valid = valid_r;
  assign mode  = mode_r;
  assign data  = data_r;
  assign carry = carry_r;

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray<->binary converter: STAGES chained codec stages with a
// backward ready chain so bubbles collapse and stalls never drop a beat.
module gray_codec_pipe
  import gray_codec_pipe_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int STAGES    = 2
) (
  input logic               clk,
  input logic               rst_n,
  gray_codec_pipe_if.slave  bus
);

  localparam int CHUNK = ceil_div(BIT_WIDTH, STAGES);

  logic unused_carry_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                 valid_s;
    logic                 mode_s;
    logic                 carry_s;
    logic                 ready_s;
    logic [BIT_WIDTH-1:0] data_s;
    logic                 prev_valid_s;
    logic                 prev_mode_s;
    logic                 prev_carry_s;
    logic [BIT_WIDTH-1:0] prev_data_s;
    logic                 next_ready_s;

    if (k == 0) begin : g_first
      assign prev_valid_s = bus.in_valid;
      assign prev_mode_s  = bus.in_mode;
      assign prev_data_s  = bus.in_data;
      assign prev_carry_s = 1'b0;
    end else begin : g_chain
      assign prev_valid_s = g_stage[k-1].valid_s;
      assign prev_mode_s  = g_stage[k-1].mode_s;
      assign prev_data_s  = g_stage[k-1].data_s;
      assign prev_carry_s = g_stage[k-1].carry_s;
    end

    if (k == STAGES - 1) begin : g_last
      assign next_ready_s = bus.out_ready;
    end else begin : g_next
      assign next_ready_s = g_stage[k+1].ready_s;
    end

    gray_codec_stage #(
      .BIT_WIDTH (BIT_WIDTH),
      .CHUNK     (CHUNK),
      .STAGE_IDX (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .prev_valid (prev_valid_s),
      .prev_mode  (prev_mode_s),
      .prev_data  (prev_data_s),
      .prev_carry (prev_carry_s),
      .next_ready (next_ready_s),
      .valid      (valid_s),
      .mode       (mode_s),
      .data       (data_s),
      .carry      (carry_s),
      .ready      (ready_s)
    );
  end

  // The final carry has no consumer; the result word already holds every resolved bit.
  assign unused_carry_s = g_stage[STAGES-1].carry_s;

  assign bus.in_ready  = g_stage[0].ready_s;
  assign bus.out_valid = g_stage[STAGES-1].valid_s;
  assign bus.out_mode  = g_stage[STAGES-1].mode_s;
  assign bus.out_data  = g_stage[STAGES-1].data_s;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Self-checking bench for gray_codec_pipe: directed beats, full sweeps,
// backpressure, mid-stream reset, and random streams on corner configurations.
module tb_gray_codec_pipe;
  import gray_codec_pipe_pkg::*;

  localparam int W = 8;
  localparam int S = 2;

  typedef struct packed {
    logic [31:0] exp;
    logic        mode;
    logic        nobp;
    logic [31:0] stamp;
  } ent_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic rst_c_n = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   cyc     = 0;
  bit   corner_done [3];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  gray_codec_pipe_if #(.BIT_WIDTH(W)) mif ();
  gray_codec_pipe #(.BIT_WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(mif));

  // Reference: Gray->binary is the XOR of all right shifts, binary->Gray is x ^ (x >> 1).
  function automatic logic [31:0] ref_conv(input logic m, input logic [31:0] x, input int w);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r    = 32'd0;
    if (m == MODE_B2G) r = x ^ (x >> 1);
    else for (int k = 0; k < w; k++) r = r ^ (x >> k);
    return r & mask;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Main scoreboard
  ent_t        exp_q [$];
  logic [7:0]  cap_q [$];
  bit          capture = 1'b0;

  initial begin : main_mon
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (mif.out_valid && mif.out_ready) begin
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_data", 32'(mif.out_data), e.exp);
            check("sb_mode", 32'(mif.out_mode), 32'(e.mode));
            if (capture) cap_q.push_back(mif.out_data);
          end
        end
        if (mif.in_valid && mif.in_ready)
          exp_q.push_back('{exp: ref_conv(mif.in_mode, 32'(mif.in_data), W),
                            mode: mif.in_mode, nobp: 1'b0, stamp: 32'(cyc)});
      end
    end
  end

  task automatic directed(input logic m, input logic [7:0] d, input logic [7:0] exp, input string tag);
    mif.in_mode  = m;
    mif.in_data  = d;
    mif.in_valid = 1'b1;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    check({tag, "_early"}, 32'(mif.out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(mif.out_valid), 32'd1);
    check({tag, "_data"}, 32'(mif.out_data), 32'(exp));
    check({tag, "_mode"}, 32'(mif.out_mode), 32'(m));
    @(posedge clk); #1;
  endtask

  task automatic stream_beat(input logic m, input logic [7:0] d, inout int stalls);
    mif.in_valid = 1'b1;
    mif.in_mode  = m;
    mif.in_data  = d;
    @(negedge clk);
    if (!mif.in_ready) stalls++;
    @(posedge clk); #1;
  endtask

  initial begin : main_seq
    int         stalls;
    bit         took;
    logic [7:0] g_arr [256];
    logic       first_mode;
    logic [7:0] first_data;

    mif.in_valid  = 1'b0;
    mif.in_mode   = 1'b0;
    mif.in_data   = 8'd0;
    mif.out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(mif.out_valid), 32'd0);
    check("rst_out_data", 32'(mif.out_data), 32'd0);
    check("rst_out_mode", 32'(mif.out_mode), 32'd0);
    check("rst_in_ready", 32'(mif.in_ready), 32'd1);
    @(negedge clk);
    rst_n   = 1'b1;
    rst_c_n = 1'b1;
    @(posedge clk); #1;

    directed(MODE_G2B, 8'hC0, 8'h80, "g2b_c0");
    directed(MODE_G2B, 8'h80, 8'hFF, "g2b_80");
    directed(MODE_B2G, 8'hFF, 8'h80, "b2g_ff");
    directed(MODE_B2G, 8'h80, 8'hC0, "b2g_80");

    stalls = 0;
    for (int i = 0; i < 8; i++) stream_beat(1'(i % 2), 8'($urandom), stalls);
    mif.in_valid = 1'b0;
    repeat (S + 2) @(posedge clk);
    #1;
    check("alt_stalls", 32'(stalls), 32'd0);
    check("alt_drained", 32'(exp_q.size()), 32'd0);

    capture = 1'b1;
    stalls  = 0;
    for (int i = 0; i < 256; i++) stream_beat(MODE_G2B, 8'(i), stalls);
    mif.in_valid = 1'b0;
    repeat (S + 2) @(posedge clk);
    #1;
    check("sweep_g2b_stalls", 32'(stalls), 32'd0);
    check("sweep_g2b_count", 32'(cap_q.size()), 32'd256);
    for (int i = 0; i < 256; i++) g_arr[i] = (i < cap_q.size()) ? cap_q[i] : 8'd0;
    cap_q.delete();
    stalls = 0;
    for (int i = 0; i < 256; i++) stream_beat(MODE_B2G, g_arr[i], stalls);
    mif.in_valid = 1'b0;
    repeat (S + 2) @(posedge clk);
    #1;
    check("sweep_b2g_stalls", 32'(stalls), 32'd0);
    check("sweep_b2g_count", 32'(cap_q.size()), 32'd256);
    for (int i = 0; i < cap_q.size(); i++) check("roundtrip", 32'(cap_q[i]), 32'(i));
    capture = 1'b0;

    mif.out_ready = 1'b0;
    mif.in_valid  = 1'b1;
    first_mode    = 1'($urandom_range(1, 0));
    first_data    = 8'($urandom);
    mif.in_mode   = first_mode;
    mif.in_data   = first_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(mif.in_ready), 32'(c < S));
      if (c >= S) begin
        check("bp_out_valid", 32'(mif.out_valid), 32'd1);
        check("bp_hold_data", 32'(mif.out_data), ref_conv(first_mode, 32'(first_data), W));
        check("bp_hold_mode", 32'(mif.out_mode), 32'(first_mode));
      end
      took = mif.in_ready;
      @(posedge clk); #1;
      if (took) begin
        mif.in_mode = 1'($urandom_range(1, 0));
        mif.in_data = 8'($urandom);
      end
    end
    mif.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      took = mif.in_ready;
      @(posedge clk); #1;
      if (took) begin
        mif.in_mode = 1'($urandom_range(1, 0));
        mif.in_data = 8'($urandom);
      end
    end
    mif.in_valid = 1'b0;
    repeat (S + 4) @(posedge clk);
    #1;
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    mif.in_valid = 1'b1;
    mif.in_mode  = MODE_B2G;
    mif.in_data  = 8'h80;
    @(posedge clk); #1;
    mif.in_mode  = MODE_G2B;
    mif.in_data  = 8'hC0;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    check("pre_rst_valid", 32'(mif.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(mif.out_valid), 32'd0);
    check("rst_mid_out_data", 32'(mif.out_data), 32'd0);
    check("rst_mid_out_mode", 32'(mif.out_mode), 32'd0);
    check("rst_mid_in_ready", 32'(mif.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_no_stale", 32'(mif.out_valid), 32'd0);
    end

    for (int t = 0; t < 30000; t++) begin
      if (corner_done[0] && corner_done[1] && corner_done[2]) break;
      @(posedge clk);
    end
    check("corner_done", {29'd0, corner_done[2], corner_done[1], corner_done[0]}, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Corner configurations: random streams with handshake-aware driver and latency check.
  for (genvar g = 0; g < 3; g++) begin : g_corner
    localparam int CW = (g == 0) ? 5 : ((g == 1) ? 32 : 4);
    localparam int CS = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    gray_codec_pipe_if #(.BIT_WIDTH(CW)) cif ();
    gray_codec_pipe #(.BIT_WIDTH(CW), .STAGES(CS)) cdut (.clk(clk), .rst_n(rst_c_n), .bus(cif));

    ent_t q [$];
    int   sent = 0;
    bit   took = 1'b0;

    initial begin : mon
      ent_t e;
      forever begin
        @(negedge clk);
        if (rst_c_n) begin
          took = 1'b0;
          if (cif.out_valid && cif.out_ready) begin
            check($sformatf("c%0d_nonempty", g), 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
              e = q.pop_front();
              check($sformatf("c%0d_data", g), 32'(cif.out_data), e.exp);
              check($sformatf("c%0d_mode", g), 32'(cif.out_mode), 32'(e.mode));
              if (e.nobp) check($sformatf("c%0d_latency", g), 32'(cyc) - e.stamp, 32'(CS));
            end
          end
          if (cif.in_valid && cif.in_ready) begin
            q.push_back('{exp: ref_conv(cif.in_mode, 32'(cif.in_data), CW),
                          mode: cif.in_mode, nobp: (sent < 16), stamp: 32'(cyc)});
            sent++;
            took = 1'b1;
          end
        end
      end
    end

    initial begin : drv
      cif.in_valid  = 1'b0;
      cif.in_mode   = 1'b0;
      cif.in_data   = '0;
      cif.out_ready = 1'b1;
      wait (rst_c_n);
      @(posedge clk); #1;
      for (int t = 0; t < 20000 && sent < 1000; t++) begin
        if (!cif.in_valid || took) begin
          cif.in_valid = (sent < 20) ? 1'b1 : 1'($urandom_range(3, 0) != 0);
          cif.in_mode  = 1'($urandom_range(1, 0));
          cif.in_data  = CW'($urandom);
        end
        cif.out_ready = (sent < 20) ? 1'b1 : 1'($urandom_range(3, 0) != 0);
        @(posedge clk); #1;
      end
      cif.in_valid  = 1'b0;
      cif.out_ready = 1'b1;
      for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
      #1;
      check($sformatf("c%0d_sent", g), 32'(sent), 32'd1000);
      check($sformatf("c%0d_drained", g), 32'(q.size()), 32'd0);
      corner_done[g] = 1'b1;
    end
  end

endmodule
